// File: rtl/aes_pkg.sv
// Shared AES definitions: byte width, SubBytes FSM states and S-box mode encodings.
package aes_pkg;

    localparam int AES_BYTE_W = 8;

    typedef enum logic [1:0] {
        SB_IDLE = 2'd0,
        SB_BUSY = 2'd1,
        SB_DONE = 2'd2
    } sb_state_e;

    typedef enum logic {
        SB_FWD = 1'b0,
        SB_INV = 1'b1
    } sb_mode_e;

    // Beat counter width: enough to hold BEATS-1, never narrower than one bit.
    function automatic int sb_cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/aes_sbox_dual.sv
// Combinational AES S-box lane with forward/inverse select.
module aes_sbox_dual
    import aes_pkg::*;
(
    input  sb_mode_e              mode,
    input  logic [AES_BYTE_W-1:0] byte_in,
    output logic [AES_BYTE_W-1:0] byte_out
);

    localparam logic [7:0] FWD_TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_TABLE [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Table lookup; the mode picks between the two images of the same byte.
    always_comb begin
        byte_out = (mode == SB_INV) ? INV_TABLE[byte_in] : FWD_TABLE[byte_in];
    end

endmodule

// File: rtl/sub_bytes_seq.sv
// Sequential SubBytes engine: one DATA_W state per transaction, NUM_SBOX bytes per cycle.
//
// state   | meaning
// --------+------------------------------------------------------------
// SB_IDLE | ready for a new state (in_ready=1)
// SB_BUSY | substituting NUM_SBOX bytes per cycle, BEATS cycles total
// SB_DONE | result held on out_data until out_ready handshake
module sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int DATA_W   = 128,
    parameter int NUM_SBOX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              mode,
    input  logic              enable,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    // DATA_W must be a byte multiple and NUM_SBOX must divide the byte count.
    localparam int NUM_BYTES = DATA_W / AES_BYTE_W;
    localparam int BEATS     = NUM_BYTES / NUM_SBOX;
    localparam int LANE_W    = NUM_SBOX * AES_BYTE_W;
    localparam int CNT_W     = sb_cnt_w(BEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    sb_state_e         state;
    sb_mode_e          mode_q;
    logic              enable_q;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] work;
    logic [LANE_W-1:0] lane_out;
    logic [DATA_W-1:0] work_next;

    // The working register rotates right by one lane group per beat, so the
    // S-box lanes always read the low bytes: no wide byte-select mux is needed,
    // bytes are processed lowest index first, and after BEATS rotations every
    // byte is back in its original position.
    for (genvar l = 0; l < NUM_SBOX; l++) begin : g_lane
        aes_sbox_dual u_sbox (
            .mode     (mode_q),
            .byte_in  (work[l*AES_BYTE_W +: AES_BYTE_W]),
            .byte_out (lane_out[l*AES_BYTE_W +: AES_BYTE_W])
        );
    end

    if (BEATS == 1) begin : g_parallel
        // Fully parallel: the whole state is substituted in one cycle.
        always_comb begin
            work_next = lane_out;
        end
    end else begin : g_rotate
        // Substituted group re-enters at the top while the rest shifts down.
        always_comb begin
            work_next = {lane_out, work[DATA_W-1:LANE_W]};
        end
    end

    assign out_data = work;

    // Control FSM with registered handshake outputs and working register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= SB_IDLE;
            mode_q    <= SB_FWD;
            enable_q  <= 1'b0;
            cnt       <= '0;
            work      <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                SB_IDLE: begin
                    if (in_valid && in_ready) begin
                        work     <= in_data;
                        mode_q   <= sb_mode_e'(mode);
                        enable_q <= enable;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= enable ? SB_BUSY : SB_DONE;
                    end
                end
                SB_BUSY: begin
                    work <= work_next;
                    if (cnt == LAST_CNT) begin
                        out_valid <= 1'b1;
                        state     <= SB_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SB_DONE: begin
                    // A bypassed state spends one settle cycle here before
                    // out_valid rises, giving a one-cycle bypass latency.
                    if (!out_valid && !enable_q) begin
                        out_valid <= 1'b1;
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= SB_IDLE;
                    end
                end
                default: begin
                    state     <= SB_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/sub_bytes_seq.md
Name: sub_bytes_seq

Overview:
- Sequential, parametrised SubBytes engine for the AES core.
- Accepts a DATA_W-bit state over a valid/ready handshake and runs it through NUM_SBOX S-box lanes, NUM_SBOX bytes per cycle.
- Supports forward (encrypt) and inverse (decrypt) substitution, plus a per-transaction bypass.
- Sits between the round-key/ShiftRows stages; lets area-constrained builds trade S-box count for latency.

Parameters:
- DATA_W, 128, state width in bits; multiple of 8.
- NUM_SBOX, 4, S-box lanes; must divide DATA_W/8.
- Derived BEATS = (DATA_W/8)/NUM_SBOX, processing cycles per transaction.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  upstream has a state on in_data.
- in_ready  output  1  engine can accept a state.
- in_data  input  DATA_W  input state; byte i = in_data[8i+7:8i].
- mode  input  1  0 = forward S-box, 1 = inverse S-box; sampled at accept.
- enable  input  1  1 = substitute, 0 = bypass; sampled at accept.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  DATA_W  result state; same byte ordering.

Behaviour:
- Reset: one clock, synchronous, active-low; sampled only at rising clk edges.
- While rst_n=0:
  - state returns to IDLE; out_valid=0; out_data=0.
  - beat counter=0; captured mode/enable=0.
  - in_ready=1 after the reset edge.
  - in_valid is ignored while rst_n=0.
- Reset mid-operation discards the transaction in flight; no partial result is ever presented.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_data, mode and enable into working registers; clear beat counter.
  - Go to BUSY if enable=1, else DONE.
- BUSY:
  - in_ready=0.
  - Each cycle, bytes [cnt*NUM_SBOX .. cnt*NUM_SBOX+NUM_SBOX-1] of the working register are replaced by their S-box (mode=0) or inverse S-box (mode=1) image; cnt increments.
  - Bytes are processed lowest index first.
  - When cnt = BEATS-1 is processed, go to DONE.
- DONE:
  - out_valid=1; out_data = working register, stable until the handshake completes.
  - On out_ready=1: out_valid drops, go to IDLE.
  - No acceptance in DONE (in_ready=0). This is a non-overlapped, single-buffer design.
- Latency, with the accept edge = T:
  - Substitute: out_valid first high after edge T+BEATS (4 cycles at defaults).
  - Bypass: out_valid after edge T+1; out_data = in_data unchanged.
- Boundary cases:
  - out_ready held low: DONE persists indefinitely with data stable.
  - out_ready already high on DONE entry: one-cycle out_valid pulse.
  - NUM_SBOX = DATA_W/8: BEATS=1; one BUSY cycle, fully parallel.
  - Counter width: clog2(BEATS), minimum 1 bit; no wrap beyond BEATS-1.
- mode/enable changes after accept have no effect on the current transaction.
- Throughput: one transaction per BEATS+2 cycles with out_ready tied high.

Decomposition:
- Shared package aes_pkg holds:
  - AES_BYTE_W = 8.
  - FSM state encodings: SB_IDLE, SB_BUSY, SB_DONE.
  - Mode encodings: SB_FWD = 0, SB_INV = 1.
- Natural sub-module aes_sbox_dual:
  - Combinational 8-bit forward/inverse S-box with a mode select.
  - Instantiated NUM_SBOX times via generate.
  - Reuses the existing forward S-box table and adds the inverse table.

Test Plan:
- Forward, defaults: in_data=0x00112233445566778899aabbccddeeff, mode=0, enable=1, out_ready=1 -> out_valid after exactly 4 cycles, out_data=0x638293c31bfc33f5c4eeacea4bc12816 (byte 0 = LSB byte).
- Inverse round-trip: feed 0x638293c31bfc33f5c4eeacea4bc12816 with mode=1 -> out_data=0x00112233445566778899aabbccddeeff. Also all-0x63 state -> all-0x00.
- Bypass: enable=0, in_data=0xDEADBEEF... -> out_valid after 1 cycle, out_data identical to input, mode ignored.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0, a new in_valid is not accepted. Then out_ready=1 -> in_ready=1 the next cycle.
- Reset mid-BUSY: assert rst_n=0 after 2 beats -> next edge out_valid=0, out_data=0, in_ready=1. A following transaction produces a correct result with no residue.
- Parameter sweep: NUM_SBOX=1, 2, 16 with the forward vector -> latency 16, 8, 1 cycles respectively, identical out_data. Compare against a reference model over 1000 random states/modes.
